// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the one-hot decoder/scan sequencer.
package onehot_decoder_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN_UP = 2'b01,
    MODE_SCAN_DN = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

endpackage

// File: rtl/onehot_decoder_seq_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W binary to one-hot decoder.
module onehot_dec #(
  parameter  int SEL_W = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  // Shift a single set bit into position idx.
  always_comb begin
    onehot = OUT_W'(1) << idx;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with direct load handshake and
// up/down auto-scan with programmable dwell, hold mode and wrap pulse.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter  int SEL_W   = 4,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  mode_e              mode_in;
  mode_e              mode_q, mode_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [OUT_W-1:0]   dec_y;
  logic               load;

  assign mode_in = mode_e'(mode);

  // Loads are only accepted in direct mode while enabled; reset blocks the handshake.
  assign sel_ready = en && !rst && (mode_in == MODE_DIRECT);
  assign load      = sel_valid && sel_ready;

  // y is registered from the decode of the next index so it is a clean flop output.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx    (idx_d),
    .onehot (dec_y)
  );

  // Next-state: enable gating, mode-change counter clear, direct load, scan stepping.
  always_comb begin
    mode_d  = mode_in;
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (mode_in)
        MODE_DIRECT: begin
          cnt_d = '0;
          if (load) begin
            idx_d   = sel;
            valid_d = 1'b1;
          end
        end
        MODE_SCAN_UP, MODE_SCAN_DN: begin
          // A mode change or first valid cycle shows the current index without stepping.
          if ((mode_in != mode_q) || !valid_q) begin
            valid_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q >= dwell) begin
            // >= rather than == so a dwell reduced below the count steps at once.
            cnt_d = '0;
            if (mode_in == MODE_SCAN_UP) begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == '1);
            end else begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
        MODE_HOLD: begin
          if (mode_in != mode_q) cnt_d = '0;
        end
      endcase
    end
    y_d = valid_d ? dec_y : '0;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_DIRECT;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
  assign idx     = idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq (SEL_W=4, DWELL_W=8).
module tb_onehot_decoder_seq;

  logic        clk = 1'b0;
  logic        rst, en, sel_valid, sel_ready, y_valid, wrap;
  logic [1:0]  mode;
  logic [3:0]  sel, idx;
  logic [7:0]  dwell;
  logic [15:0] y;

  int unsigned total = 0;
  int unsigned bad   = 0;

  onehot_decoder_seq #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .y         (y),
    .y_valid   (y_valid),
    .idx       (idx),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel_valid = 1'b0; sel = '0; dwell = '0;
    tick(); tick();
    rst = 1'b0; en = 1'b1;
    #1;
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h exp=%h", y, 16'h0000); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", y_valid); end
    total++; if (idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    total++; if (sel_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", sel_ready); end
  endtask

  task automatic test_direct();
    sel_valid = 1'b1; sel = 4'd5;
    tick();
    sel_valid = 1'b0; sel = 4'd11;
    #1;
    total++; if (y !== 16'h0020) begin bad++; $display("FAIL direct_y got=%h exp=%h", y, 16'h0020); end
    total++; if (idx !== 4'd5) begin bad++; $display("FAIL direct_idx got=%0d exp=5", idx); end
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL direct_valid got=%b exp=1", y_valid); end
    total++; if (sel_ready !== 1'b1) begin bad++; $display("FAIL direct_ready got=%b exp=1", sel_ready); end
    tick(); tick();
    total++; if (y !== 16'h0020) begin bad++; $display("FAIL direct_hold_y got=%h exp=%h", y, 16'h0020); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sels [3] = '{4'd0, 4'd15, 4'd7};
    logic [15:0] exps [3] = '{16'h0001, 16'h8000, 16'h0080};
    for (int i = 0; i < 3; i++) begin
      sel_valid = 1'b1; sel = sels[i];
      tick();
      total++; if (y !== exps[i]) begin bad++; $display("FAIL b2b_y[%0d] got=%h exp=%h", i, y, exps[i]); end
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_scan_up();
    int unsigned e_idx;
    logic        e_wrap;
    sel_valid = 1'b1; sel = 4'd14;
    tick();
    sel_valid = 1'b0; mode = 2'b01; dwell = 8'd2;
    for (int i = 0; i <= 50; i++) begin
      tick();
      e_idx  = (14 + i / 3) % 16;
      e_wrap = (i % 3 == 0) && (e_idx == 0) && (i > 0);
      total++; if (y !== (16'h0001 << e_idx)) begin bad++; $display("FAIL scan_up_y[%0d] got=%h exp=%h", i, y, 16'h0001 << e_idx); end
      total++; if (wrap !== e_wrap) begin bad++; $display("FAIL scan_up_wrap[%0d] got=%b exp=%b", i, wrap, e_wrap); end
    end
  endtask

  task automatic test_scan_down();
    logic [3:0] e_idx [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
    logic       e_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'b00; sel_valid = 1'b1; sel = 4'd1;
    tick();
    mode = 2'b10; dwell = 8'd0; sel = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (idx !== e_idx[i]) begin bad++; $display("FAIL scan_dn_idx[%0d] got=%0d exp=%0d", i, idx, e_idx[i]); end
      total++; if (wrap !== e_wrap[i]) begin bad++; $display("FAIL scan_dn_wrap[%0d] got=%b exp=%b", i, wrap, e_wrap[i]); end
      total++; if (sel_ready !== 1'b0) begin bad++; $display("FAIL scan_dn_ready[%0d] got=%b exp=0", i, sel_ready); end
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_hold();
    // idx=14 from the down run; the mode change plus 3 cycles leaves counter=3.
    mode = 2'b01; dwell = 8'd9;
    for (int i = 0; i < 4; i++) tick();
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (y !== 16'h4000) begin bad++; $display("FAIL hold_y[%0d] got=%h exp=%h", i, y, 16'h4000); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL hold_wrap[%0d] got=%b exp=0", i, wrap); end
    end
    mode = 2'b01;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k < 10) begin
        total++; if (idx !== 4'd14) begin bad++; $display("FAIL resume_idx[%0d] got=%0d exp=14", k, idx); end
      end else begin
        total++; if (idx !== 4'd15) begin bad++; $display("FAIL resume_step got=%0d exp=15", idx); end
      end
    end
  endtask

  task automatic test_disable_reset();
    en = 1'b0;
    tick();
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL dis_y got=%h exp=%h", y, 16'h0000); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL dis_valid got=%b exp=0", y_valid); end
    total++; if (idx !== 4'd15) begin bad++; $display("FAIL dis_idx got=%0d exp=15", idx); end
    total++; if (sel_ready !== 1'b0) begin bad++; $display("FAIL dis_ready got=%b exp=0", sel_ready); end
    rst = 1'b1; en = 1'b1; mode = 2'b00; sel_valid = 1'b1; sel = 4'd9;
    tick();
    rst = 1'b0; sel_valid = 1'b0;
    #1;
    total++; if (y !== 16'h0000) begin bad++; $display("FAIL rst_y got=%h exp=%h", y, 16'h0000); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", y_valid); end
    total++; if (idx !== 4'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
    tick();
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rst_noload got=%b exp=0", y_valid); end
    mode = 2'b01; dwell = 8'd0;
    tick();
    total++; if (y !== 16'h0001) begin bad++; $display("FAIL reen_first got=%h exp=%h", y, 16'h0001); end
    tick();
    total++; if (y !== 16'h0002) begin bad++; $display("FAIL reen_step got=%h exp=%h", y, 16'h0002); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_scan_up();
    test_scan_down();
    test_hold();
    test_disable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
